// File: rtl/hazard_scoreboard.sv
// Two-slot (EXE/MEM) RAW scoreboard that drives the decode-stage stall request.
// Supports forwarding and non-forwarding pipelines and keeps a saturating
// stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             has_two_src,
  input  logic             ignore_hazard,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  output logic             hazard,
  output logic [REG_W-1:0] exe_dest,
  output logic             exe_pending,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r_en;
    logic [REG_W-1:0] dest;
  } slot_t;

  slot_t slot_exe, slot_mem, id_slot;
  logic  exe_hit, mem_hit;

  // The MEM-stage load flag travels with the slot but nothing consumes it here.
  logic  unused_mem_ld;
  assign unused_mem_ld = slot_mem.mem_r_en;

  function automatic logic hit(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && s.wb_en && (s.dest == r);
  endfunction

  // RAW detection; with forwarding only a load sitting in EXE must stall.
  always_comb begin
    exe_hit = hit(slot_exe, src1) || (has_two_src && hit(slot_exe, src2));
    mem_hit = hit(slot_mem, src1) || (has_two_src && hit(slot_mem, src2));
    hazard  = 1'b0;
    if (!ignore_hazard)
      hazard = fwd_en ? (exe_hit && slot_exe.mem_r_en) : (exe_hit || mem_hit);
  end

  // Slot image of the decode-stage instruction; flush or stall turns it into a bubble.
  always_comb begin
    id_slot = slot_t'{1'b1, id_wb_en, id_mem_r_en, id_dest};
    if (flush || hazard) id_slot = '0;
  end

  // Scoreboard advance; freeze holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_exe <= '0;
      slot_mem <= '0;
    end else if (!freeze) begin
      slot_mem <= slot_exe;
      slot_exe <= id_slot;
    end
  end

  // Saturating count of unfrozen stall edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (!freeze && hazard && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

  assign exe_dest    = slot_exe.dest;
  assign exe_pending = slot_exe.valid && slot_exe.wb_en;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed table, hand sequences for multi-cycle
// corners, and random traffic against a queue-based in-flight model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, fwd_en;
  logic [3:0]  src1, src2, id_dest;
  logic        has_two_src, ignore_hazard, id_wb_en, id_mem_r_en;
  logic        hazard, exe_pending;
  logic [3:0]  exe_dest;
  logic [15:0] stall_cycles;
  // narrow-counter twin, same inputs, used to reach saturation quickly
  logic        hazard_s, exe_pending_s;
  logic [3:0]  exe_dest_s, stall_s;

  hazard_scoreboard #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
    .src1(src1), .src2(src2), .has_two_src(has_two_src), .ignore_hazard(ignore_hazard),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard(hazard), .exe_dest(exe_dest), .exe_pending(exe_pending),
    .stall_cycles(stall_cycles));

  hazard_scoreboard #(.REG_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
    .src1(src1), .src2(src2), .has_two_src(has_two_src), .ignore_hazard(ignore_hazard),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard(hazard_s), .exe_dest(exe_dest_s), .exe_pending(exe_pending_s),
    .stall_cycles(stall_s));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model: list of in-flight instructions ----------
  typedef struct {
    logic [3:0] dest;
    bit         wb;
    bit         ld;
    int         age;   // unfrozen edges since acceptance: 0 = EXE, 1 = MEM
  } ent_t;
  ent_t q[$];
  int   mcnt;

  function automatic bit m_haz();
    bit h = 1'b0;
    if (ignore_hazard) return 1'b0;
    foreach (q[i])
      if (q[i].wb && (q[i].dest == src1 || (has_two_src && q[i].dest == src2)) &&
          (!fwd_en || (q[i].age == 0 && q[i].ld)))
        h = 1'b1;
    return h;
  endfunction

  function automatic bit m_pending();
    foreach (q[i]) if (q[i].age == 0) return q[i].wb;
    return 1'b0;
  endfunction

  function automatic int m_dest();
    foreach (q[i]) if (q[i].age == 0) return int'(q[i].dest);
    return 0;
  endfunction

  task automatic model_edge();
    ent_t nq[$];
    bit   h;
    if (!rst || freeze) return;
    h = m_haz();
    if (h) mcnt++;
    foreach (q[i]) if (q[i].age == 0) begin
      ent_t e = q[i];
      e.age = 1;
      nq.push_back(e);
    end
    q = nq;
    if (!(flush || h)) q.push_back('{id_dest, id_wb_en, id_mem_r_en, 0});
  endtask

  task automatic model_reset();
    q.delete();
    mcnt = 0;
  endtask

  // ---------------- checking helpers -----------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("hazard",       32'(hazard),       32'(m_haz()));
    chk("exe_pending",  32'(exe_pending),  32'(m_pending()));
    chk("exe_dest",     32'(exe_dest),     32'(m_dest()));
    chk("stall_cycles", 32'(stall_cycles), 32'(mcnt));
    chk("stall_sat4",   32'(stall_s),      32'(mcnt > 15 ? 15 : mcnt));
    chk("hazard_twin",  32'(hazard_s),     32'(m_haz()));
  endtask

  // one clock: check at negedge, update model at posedge, return 1 after it
  task automatic cyc();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    freeze = 0; flush = 0; ignore_hazard = 1; has_two_src = 0;
    src1 = 0; src2 = 0; id_wb_en = 0; id_mem_r_en = 0; id_dest = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    @(posedge clk);
    #1 rst = 1;
  endtask

  // issue a writer, present a consumer, expect n_exp stall cycles then none
  task automatic run_stall(input bit fwd, input bit ld, input bit use2,
                           input logic [3:0] d, input int n_exp);
    do_reset();
    idle();
    fwd_en = fwd;
    id_wb_en = 1; id_mem_r_en = ld; id_dest = d;
    cyc();
    idle();
    ignore_hazard = 0;
    if (use2) begin src2 = d; has_two_src = 1; src1 = 4'd9; end
    else src1 = d;
    for (int i = 0; i <= n_exp; i++) begin
      @(negedge clk);
      chk("stall_seq_hazard", 32'(hazard), 32'(i < n_exp));
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end
    @(negedge clk);
    chk("stall_seq_count", 32'(stall_cycles), 32'(n_exp));
  endtask

  // ---------------- directed one-cycle table ----------------------------------
  typedef struct {
    bit         fwd;
    bit         p_wb;
    bit         p_ld;
    logic [3:0] p_dest;
    logic [3:0] s1;
    logic [3:0] s2;
    bit         two;
    bit         ign;
    bit         exp_h;
  } vec_t;
  vec_t vt[10];

  initial begin
    vt[0] = '{0, 1, 0, 4'd3,  4'd3,  4'd0, 0, 0, 1};  // plain RAW
    vt[1] = '{0, 1, 0, 4'd3,  4'd0,  4'd3, 0, 0, 0};  // src2 not a source
    vt[2] = '{0, 1, 0, 4'd3,  4'd0,  4'd3, 1, 0, 1};  // src2 is a source
    vt[3] = '{0, 1, 0, 4'd3,  4'd3,  4'd0, 0, 1, 0};  // reads nothing
    vt[4] = '{0, 0, 0, 4'd3,  4'd3,  4'd0, 0, 0, 0};  // store in EXE
    vt[5] = '{1, 1, 1, 4'd5,  4'd0,  4'd5, 1, 0, 1};  // load-use, forwarding
    vt[6] = '{1, 1, 0, 4'd5,  4'd0,  4'd5, 1, 0, 0};  // ALU op forwarded
    vt[7] = '{0, 1, 0, 4'd15, 4'd15, 4'd0, 0, 0, 1};  // R15 no special case
    vt[8] = '{1, 0, 1, 4'd5,  4'd5,  4'd0, 0, 0, 0};  // load flag without write
    vt[9] = '{0, 1, 0, 4'd3,  4'd4,  4'd2, 1, 0, 0};  // no match

    idle();
    fwd_en = 0;
    rst = 0;
    model_reset();
    #1;
    chk("reset_hazard",  32'(hazard),       32'd0);
    chk("reset_stall",   32'(stall_cycles), 32'd0);
    chk("reset_pending", 32'(exe_pending),  32'd0);
    @(posedge clk);
    #1 rst = 1;
    id_wb_en = 1; id_dest = 4'd3;
    cyc();
    @(negedge clk);
    chk("first_pending", 32'(exe_pending), 32'd1);
    chk("first_dest",    32'(exe_dest),    32'd3);

    foreach (vt[k]) begin
      do_reset();
      idle();
      fwd_en = vt[k].fwd;
      id_wb_en = vt[k].p_wb; id_mem_r_en = vt[k].p_ld; id_dest = vt[k].p_dest;
      cyc();
      idle();
      ignore_hazard = vt[k].ign; src1 = vt[k].s1; src2 = vt[k].s2;
      has_two_src = vt[k].two;
      @(negedge clk);
      chk($sformatf("vec%0d_hazard", k), 32'(hazard), 32'(vt[k].exp_h));
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end

    run_stall(0, 0, 0, 4'd3, 2);  // no-forward RAW
    run_stall(1, 1, 1, 4'd5, 1);  // load-use with forwarding
    run_stall(1, 0, 1, 4'd5, 0);  // ALU writer, forwarded

    // freeze holds the stall, then it drains normally
    do_reset();
    idle();
    fwd_en = 0;
    id_wb_en = 1; id_dest = 4'd3;
    cyc();
    idle();
    ignore_hazard = 0; src1 = 4'd3; freeze = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("frz_hazard",  32'(hazard),       32'd1);
      chk("frz_pending", 32'(exe_pending),  32'd1);
      chk("frz_dest",    32'(exe_dest),     32'd3);
      chk("frz_stall",   32'(stall_cycles), 32'd0);
      @(posedge clk);
      model_edge();
      #1;
    end
    freeze = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("unfrz_hazard", 32'(hazard), 32'(i < 2));
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end
    @(negedge clk);
    chk("unfrz_stall", 32'(stall_cycles), 32'd2);

    // flush squashes a writer to R7
    @(posedge clk);
    model_edge();
    #1;
    idle();
    id_wb_en = 1; id_dest = 4'd7; flush = 1;
    cyc();
    flush = 0;
    @(negedge clk);
    chk("flush_pending", 32'(exe_pending), 32'd0);
    check_model();

    // async reset in the middle of a stall
    do_reset();
    idle();
    fwd_en = 0;
    id_wb_en = 1; id_dest = 4'd3;
    cyc();
    idle();
    ignore_hazard = 0; src1 = 4'd3;
    cyc();
    #2 rst = 0;
    model_reset();
    #1;
    chk("arst_hazard",  32'(hazard),       32'd0);
    chk("arst_stall",   32'(stall_cycles), 32'd0);
    chk("arst_pending", 32'(exe_pending),  32'd0);
    @(posedge clk);
    #1 rst = 1;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) fwd_en = 1'($urandom);
      freeze        = ($urandom_range(7) == 0);
      flush         = ($urandom_range(7) == 0);
      ignore_hazard = ($urandom_range(5) == 0);
      has_two_src   = 1'($urandom);
      src1          = ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(3));
      src2          = 4'($urandom_range(3));
      id_wb_en      = ($urandom_range(3) != 0);
      id_mem_r_en   = 1'($urandom);
      id_dest       = ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(3));
      cyc();
    end
    @(negedge clk);
    chk("sat4_reached", 32'(stall_s), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
